// File: rtl/hazard_scheduler_pkg.sv
// Shared encodings for the hazard scheduler: refill-arbiter states, forward
// selects and the write-mode constant meaning "no register write".
package hazard_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_WAIT = 2'd1,
        I_WAIT = 2'd2
    } arb_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [2:0] NOREGWRITE = 3'd0;

    // MEM has the younger result, so it wins over WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic [2:0] wr_m,
        input logic [4:0] rd_w,
        input logic [2:0] wr_w
    );
        if (wr_m != NOREGWRITE && rd_m != 5'd0 && rd_m == rs)
            return FWD_MEM;
        else if (wr_w != NOREGWRITE && rd_w != 5'd0 && rd_w == rs)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_scheduler_mem_port_arbiter.sv
// Owner FSM for the single refill port shared by I- and D-cache; also
// qualifies the miss levels into stall requests that drop on the ack cycle.
module mem_port_arbiter
    import hazard_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic icache_miss,
    input  logic dcache_miss,
    input  logic mem_ack,
    output logic mem_req,
    output logic mem_sel,
    output logic dstall,
    output logic istall
);

    arb_state_t state_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (dcache_miss)
                        state_reg <= D_WAIT;
                    else if (icache_miss)
                        state_reg <= I_WAIT;
                end
                D_WAIT: begin
                    if (mem_ack)
                        state_reg <= icache_miss ? I_WAIT : IDLE;
                end
                I_WAIT: begin
                    if (mem_ack)
                        state_reg <= dcache_miss ? D_WAIT : IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_req = (state_reg != IDLE);
    assign mem_sel = (state_reg == D_WAIT);

    // The ack cycle is the last one the requester has to wait for.
    assign dstall = dcache_miss && !(state_reg == D_WAIT && mem_ack);
    assign istall = icache_miss && !(state_reg == I_WAIT && mem_ack);

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline stall/flush/forward control for the 5-stage core, plus the refill
// port arbiter and a stall-cycle counter.
module hazard_scheduler
    import hazard_scheduler_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST_N,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [1:0]       RegReadD,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             MemToRegE,
    input  logic             BranchE,
    input  logic             JalrE,
    input  logic             JalD,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [2:0]       RegWriteM,
    input  logic [2:0]       RegWriteW,
    input  logic             ICacheMiss,
    input  logic             DCacheMiss,
    input  logic             MemAck,
    output logic             MemReq,
    output logic             MemSel,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushF,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic [1:0]       Forward1E,
    output logic [1:0]       Forward2E,
    output logic [CNT_W-1:0] StallCycles
);

    logic             dstall;
    logic             istall;
    logic             redirect;
    logic             load_use;
    logic [4:0]       rs_e     [2];
    logic [1:0]       fwd      [2];
    logic [CNT_W-1:0] stall_cycles_reg;

    mem_port_arbiter u_arb (
        .clk         (CPU_CLK),
        .rst_n       (CPU_RST_N),
        .icache_miss (ICacheMiss),
        .dcache_miss (DCacheMiss),
        .mem_ack     (MemAck),
        .mem_req     (MemReq),
        .mem_sel     (MemSel),
        .dstall      (dstall),
        .istall      (istall)
    );

    assign redirect = BranchE || JalrE;
    assign load_use = MemToRegE && (RdE != 5'd0) &&
                      ((RegReadD[1] && RdE == Rs1D) || (RegReadD[0] && RdE == Rs2D));

    // Priority: reset > D-miss freeze > EX redirect > load-use > I-miss, then jal.
    // Holding D on load-use takes precedence over bubbling it.
    always_comb begin
        StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0; StallW = 1'b0;
        FlushF = 1'b0; FlushD = 1'b0; FlushE = 1'b0; FlushM = 1'b0; FlushW = 1'b0;
        if (!CPU_RST_N) begin
            FlushF = 1'b1; FlushD = 1'b1; FlushE = 1'b1; FlushM = 1'b1; FlushW = 1'b1;
        end else if (dstall) begin
            StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
            FlushW = 1'b1;
        end else if (redirect) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end else begin
                if (istall) begin
                    StallF = 1'b1;
                    FlushD = 1'b1;
                end
                if (JalD)
                    FlushD = 1'b1;
            end
        end
    end

    assign rs_e[0] = Rs1E;
    assign rs_e[1] = Rs2E;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd[gi] = CPU_RST_N ? fwd_sel(rs_e[gi], RdM, RegWriteM, RdW, RegWriteW)
                                       : FWD_RF;
        end
    endgenerate

    assign Forward1E = fwd[0];
    assign Forward2E = fwd[1];

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N)
            stall_cycles_reg <= '0;
        else if (StallF)
            stall_cycles_reg <= stall_cycles_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign StallCycles = stall_cycles_reg;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: reset, forwarding, load-use, redirects,
// refill arbitration and the stall counter.
module tb_hazard_scheduler;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST_N;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  RegReadD;
    logic        MemToRegE, BranchE, JalrE, JalD;
    logic [2:0]  RegWriteM, RegWriteW;
    logic        ICacheMiss, DCacheMiss, MemAck;
    logic        MemReq, MemSel;
    logic        StallF, StallD, StallE, StallM, StallW;
    logic        FlushF, FlushD, FlushE, FlushM, FlushW;
    logic [1:0]  Forward1E, Forward2E;
    logic [31:0] StallCycles;
    logic [4:0]  stall, flush;

    int checks = 0;
    int failures = 0;

    hazard_scheduler #(.CNT_W(32)) dut (
        .CPU_CLK     (CPU_CLK),
        .CPU_RST_N   (CPU_RST_N),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RegReadD    (RegReadD),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .MemToRegE   (MemToRegE),
        .BranchE     (BranchE),
        .JalrE       (JalrE),
        .JalD        (JalD),
        .RdM         (RdM),
        .RdW         (RdW),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .ICacheMiss  (ICacheMiss),
        .DCacheMiss  (DCacheMiss),
        .MemAck      (MemAck),
        .MemReq      (MemReq),
        .MemSel      (MemSel),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .StallW      (StallW),
        .FlushF      (FlushF),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushM      (FlushM),
        .FlushW      (FlushW),
        .Forward1E   (Forward1E),
        .Forward2E   (Forward2E),
        .StallCycles (StallCycles)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    assign stall = {StallF, StallD, StallE, StallM, StallW};
    assign flush = {FlushF, FlushD, FlushE, FlushM, FlushW};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("ok   %s = %0h", tag, obs);
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; RegReadD = '0; Rs1E = '0; Rs2E = '0; RdE = '0;
        MemToRegE = 1'b0; BranchE = 1'b0; JalrE = 1'b0; JalD = 1'b0;
        RdM = '0; RdW = '0; RegWriteM = '0; RegWriteW = '0;
        ICacheMiss = 1'b0; DCacheMiss = 1'b0; MemAck = 1'b0;
    endtask

    initial begin
        // Reset with hazards present on the inputs: reset outputs must win.
        CPU_RST_N = 1'b0;
        clear_inputs();
        RdM = 5'd7; Rs1E = 5'd7; RegWriteM = 3'd3;
        MemToRegE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; RegReadD = 2'b10;
        DCacheMiss = 1'b1;
        #3;
        chk("rst_flush", 32'(flush), 32'(5'b11111));
        chk("rst_stall", 32'(stall), 32'(5'b00000));
        chk("rst_fwd1", 32'(Forward1E), 32'(2'b00));
        chk("rst_memreq", 32'(MemReq), 32'(1'b0));
        chk("rst_cnt", StallCycles, 32'd0);
        tick();
        tick();
        chk("rst_memreq_hold", 32'(MemReq), 32'(1'b0));
        clear_inputs();
        CPU_RST_N = 1'b1;
        #1;
        chk("idle_ctrl", 32'({stall, flush}), 32'(10'b0));

        // Forwarding
        RdM = 5'd7; RdW = 5'd7; Rs1E = 5'd7; Rs2E = 5'd7; RegWriteM = 3'd3; RegWriteW = 3'd3;
        #1;
        chk("fwd1_mem", 32'(Forward1E), 32'(2'b10));
        chk("fwd2_mem", 32'(Forward2E), 32'(2'b10));
        RdM = 5'd0;
        #1;
        chk("fwd1_rdm0_wb", 32'(Forward1E), 32'(2'b01));
        RdM = 5'd7; RegWriteM = 3'd0;
        #1;
        chk("fwd1_nowrm_wb", 32'(Forward1E), 32'(2'b01));
        RegWriteW = 3'd0;
        #1;
        chk("fwd1_none_rf", 32'(Forward1E), 32'(2'b00));
        Rs2E = 5'd3; RegWriteM = 3'd1;
        #1;
        chk("fwd1_mem_again", 32'(Forward1E), 32'(2'b10));
        chk("fwd2_nomatch_rf", 32'(Forward2E), 32'(2'b00));
        clear_inputs();

        // Load-use: lw x5 in EX, add reading x5 in ID
        tick();
        MemToRegE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; RegReadD = 2'b10;
        #1;
        chk("lu_sf_sd_fe", 32'({StallF, StallD, FlushE}), 32'(3'b111));
        chk("lu_others", 32'({StallE, StallM, StallW, FlushD, FlushW}), 32'(5'b0));
        tick();
        MemToRegE = 1'b0; RdE = 5'd0; RdM = 5'd5; RegWriteM = 3'd2; Rs1E = 5'd5;
        Rs1D = 5'd0; RegReadD = 2'b00;
        #1;
        chk("lu_released", 32'({StallF, StallD, FlushE}), 32'(3'b000));
        chk("lu_fwd1_mem", 32'(Forward1E), 32'(2'b10));
        chk("lu_cnt1", StallCycles, 32'd1);
        clear_inputs();

        tick();
        MemToRegE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; Rs2D = 5'd6; RegReadD = 2'b01;
        #1;
        chk("lu_rs1_unread", 32'(StallF), 32'(1'b0));
        Rs2D = 5'd5;
        #1;
        chk("lu_rs2_match", 32'(StallD), 32'(1'b1));
        RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0; RegReadD = 2'b11;
        #1;
        chk("lu_x0", 32'(StallF), 32'(1'b0));
        clear_inputs();

        // EX redirect overrides load-use and the I-miss fetch stall
        tick();
        MemToRegE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; RegReadD = 2'b10;
        ICacheMiss = 1'b1; BranchE = 1'b1;
        #1;
        chk("br_sf_sd_fd_fe", 32'({StallF, StallD, FlushD, FlushE}), 32'(4'b0011));
        BranchE = 1'b0; JalrE = 1'b1;
        #1;
        chk("jalr_sf_sd_fd_fe", 32'({StallF, StallD, FlushD, FlushE}), 32'(4'b0011));
        JalrE = 1'b0; MemToRegE = 1'b0;
        #1;
        chk("imiss_sf_sd_fd_fe", 32'({StallF, StallD, FlushD, FlushE}), 32'(4'b1010));
        ICacheMiss = 1'b0; JalD = 1'b1;
        #1;
        chk("jal_sf_fd_fe", 32'({StallF, FlushD, FlushE}), 32'(3'b010));
        clear_inputs();

        // Stray ack in IDLE
        tick();
        MemAck = 1'b1;
        tick();
        chk("stray_ack_req", 32'(MemReq), 32'(1'b0));
        MemAck = 1'b0;
        tick();
        chk("stray_ack_req2", 32'({MemReq, MemSel}), 32'(2'b00));

        // Clear the counter, then simultaneous I/D miss
        CPU_RST_N = 1'b0;
        #1;
        chk("cnt_cleared", StallCycles, 32'd0);
        tick();
        CPU_RST_N = 1'b1;
        ICacheMiss = 1'b1; DCacheMiss = 1'b1;
        #1;
        chk("dual_c0_stall", 32'(stall), 32'(5'b11110));
        chk("dual_c0_flush", 32'(flush), 32'(5'b00001));
        chk("dual_c0_req", 32'(MemReq), 32'(1'b0));
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 6) DCacheMiss = 1'b0;
            MemAck = (c == 5 || c == 8);
            #1;
            chk($sformatf("dual_c%0d_req", c), 32'(MemReq), 32'(1'b1));
            chk($sformatf("dual_c%0d_sel", c), 32'(MemSel), 32'(c <= 5));
            chk($sformatf("dual_c%0d_sf", c), 32'(StallF), 32'(c != 8));
            chk($sformatf("dual_c%0d_sm", c), 32'(StallM), 32'(c <= 4));
            chk($sformatf("dual_c%0d_fd", c), 32'(FlushD), 32'(c >= 5 && c <= 7));
        end
        tick();
        ICacheMiss = 1'b0; MemAck = 1'b0;
        #1;
        chk("dual_done_req", 32'(MemReq), 32'(1'b0));
        chk("dual_cnt", StallCycles, 32'd8);

        // Reset in the middle of a D refill
        DCacheMiss = 1'b1;
        tick();
        chk("dwait_req_sel", 32'({MemReq, MemSel}), 32'(2'b11));
        CPU_RST_N = 1'b0;
        #1;
        chk("midrst_req_sel", 32'({MemReq, MemSel}), 32'(2'b00));
        chk("midrst_flush", 32'(flush), 32'(5'b11111));
        chk("midrst_stall", 32'(stall), 32'(5'b00000));
        chk("midrst_cnt", StallCycles, 32'd0);
        DCacheMiss = 1'b0;
        tick();
        CPU_RST_N = 1'b1;
        #1;
        chk("postrst_req", 32'(MemReq), 32'(1'b0));
        tick();
        chk("postrst_req2", 32'(MemReq), 32'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
